// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and the memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues byte/half/word loads and stores over a req/gnt/rvalid bus,
// stalls upstream while an access is outstanding, and formats load data for writeback.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_MEM_alu_res,
    input  logic [31:0] EX_MEM_mem_din,
    input  logic [4:0]  EX_MEM_mem_ctrl,
    input  logic        EX_MEM_vld,
    mem_stage_if.master dmem,
    output logic [31:0] MEM_data,
    output logic        MEM_vld,
    output logic        MEM_stall,
    output logic        MEM_misaligned
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      r_state, w_next;
    logic [29:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [1:0]  r_lo;
    logic [31:0] r_data;

    logic        w_load, w_store, w_memop, w_conflict, w_misal;
    logic        w_is_b, w_is_h, w_accept, w_capture;
    logic [2:0]  w_f3;
    logic [1:0]  w_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld;

    assign w_load     = EX_MEM_mem_ctrl[4];
    assign w_store    = EX_MEM_mem_ctrl[3];
    assign w_memop    = EX_MEM_vld & (w_load ^ w_store);
    assign w_conflict = EX_MEM_vld & w_load & w_store;
    assign w_lo       = EX_MEM_alu_res[1:0];

    // Unlisted funct3 encodings collapse to W so all downstream decode sees only legal sizes.
    always_comb begin
        case (EX_MEM_mem_ctrl[2:0])
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3 = EX_MEM_mem_ctrl[2:0];
            default:                                w_f3 = 3'b010;
        endcase
    end

    assign w_is_b  = (w_f3[1:0] == 2'b00);
    assign w_is_h  = (w_f3[1:0] == 2'b01);
    assign w_misal = w_memop & ((w_is_h & w_lo[0]) | (~w_is_b & ~w_is_h & (w_lo != 2'b00)));

    always_comb begin
        if (w_is_b) begin
            w_be    = 4'b0001 << w_lo;
            w_wdata = {4{EX_MEM_mem_din[7:0]}};
        end else if (w_is_h) begin
            w_be    = w_lo[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{EX_MEM_mem_din[15:0]}};
        end else begin
            w_be    = 4'b1111;
            w_wdata = EX_MEM_mem_din;
        end
    end

    always_comb begin
        case (r_lo)
            2'd0:    w_byte = dmem.dmem_rdata[7:0];
            2'd1:    w_byte = dmem.dmem_rdata[15:8];
            2'd2:    w_byte = dmem.dmem_rdata[23:16];
            default: w_byte = dmem.dmem_rdata[31:24];
        endcase
        w_half = r_lo[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (r_f3)
            3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld = {24'd0, w_byte};
            3'b001:  w_ld = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld = {16'd0, w_half};
            default: w_ld = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        w_capture      = 1'b0;
        MEM_data       = EX_MEM_alu_res;
        MEM_vld        = 1'b0;
        MEM_stall      = 1'b0;
        MEM_misaligned = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_misal) begin
                    MEM_misaligned = rst;
                end else if (w_memop) begin
                    MEM_stall = 1'b1;
                    w_accept  = 1'b1;
                    w_next    = REQ;
                end else if (!w_conflict) begin
                    MEM_vld = EX_MEM_vld;
                end
            end
            REQ: begin
                MEM_stall = 1'b1;
                if (dmem.dmem_gnt) w_next = r_we ? DONE : WAIT;
            end
            WAIT: begin
                MEM_stall = 1'b1;
                if (dmem.dmem_rvalid) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE: begin
                MEM_vld  = 1'b1;
                MEM_data = r_we ? EX_MEM_alu_res : r_data;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_lo    <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= EX_MEM_alu_res[31:2];
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_we    <= w_store;
                r_f3    <= w_f3;
                r_lo    <= w_lo;
            end
            if (w_capture) r_data <= w_ld;
        end
    end

    assign dmem.dmem_req   = (r_state == REQ);
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = {r_addr, 2'b00};
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, aligned/misaligned loads and stores,
// wait-state handling and reset in the middle of a load.
module tb_mem_stage;
    logic        clk;
    logic        rst;
    logic [31:0] alu_res;
    logic [31:0] mem_din;
    logic [4:0]  mem_ctrl;
    logic        ex_vld;
    logic [31:0] mem_data;
    logic        mem_vld;
    logic        mem_stall;
    logic        mem_misal;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mem_stage_if u_if ();

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .EX_MEM_alu_res  (alu_res),
        .EX_MEM_mem_din  (mem_din),
        .EX_MEM_mem_ctrl (mem_ctrl),
        .EX_MEM_vld      (ex_vld),
        .dmem            (u_if),
        .MEM_data        (mem_data),
        .MEM_vld         (mem_vld),
        .MEM_stall       (mem_stall),
        .MEM_misaligned  (mem_misal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_txn(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] rdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_data);
        @(negedge clk);
        alu_res = addr; mem_ctrl = {2'b10, f3}; ex_vld = 1'b1;
        #1 chk({tag, " accept stall"}, 32'(mem_stall), 32'd1);
        chk({tag, " accept vld"}, 32'(mem_vld), 32'd0);
        @(negedge clk);
        u_if.dmem_gnt = 1'b1;
        #1 chk({tag, " req"}, 32'(u_if.dmem_req), 32'd1);
        chk({tag, " we"}, 32'(u_if.dmem_we), 32'd0);
        chk({tag, " addr"}, u_if.dmem_addr, {addr[31:2], 2'b00});
        chk({tag, " be"}, 32'(u_if.dmem_be), 32'(exp_be));
        @(negedge clk);
        u_if.dmem_gnt = 1'b0; u_if.dmem_rvalid = 1'b1; u_if.dmem_rdata = rdata;
        #1 chk({tag, " wait req"}, 32'(u_if.dmem_req), 32'd0);
        chk({tag, " wait stall"}, 32'(mem_stall), 32'd1);
        @(negedge clk);
        u_if.dmem_rvalid = 1'b0; u_if.dmem_rdata = 32'h5A5A5A5A;
        #1 chk({tag, " data"}, mem_data, exp_data);
        chk({tag, " done vld"}, 32'(mem_vld), 32'd1);
        chk({tag, " done stall"}, 32'(mem_stall), 32'd0);
    endtask

    task automatic store_txn(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] din, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input int unsigned gnt_delay);
        @(negedge clk);
        alu_res = addr; mem_din = din; mem_ctrl = {2'b01, f3}; ex_vld = 1'b1;
        #1 chk({tag, " accept stall"}, 32'(mem_stall), 32'd1);
        chk({tag, " accept req"}, 32'(u_if.dmem_req), 32'd0);
        for (int i = 0; i <= int'(gnt_delay); i++) begin
            @(negedge clk);
            u_if.dmem_gnt = (i == int'(gnt_delay));
            #1 chk({tag, " req"}, 32'(u_if.dmem_req), 32'd1);
            chk({tag, " we"}, 32'(u_if.dmem_we), 32'd1);
            chk({tag, " addr"}, u_if.dmem_addr, {addr[31:2], 2'b00});
            chk({tag, " be"}, 32'(u_if.dmem_be), 32'(exp_be));
            chk({tag, " wdata"}, u_if.dmem_wdata, exp_wdata);
            chk({tag, " req vld"}, 32'(mem_vld), 32'd0);
        end
        @(negedge clk);
        u_if.dmem_gnt = 1'b0;
        #1 chk({tag, " done req"}, 32'(u_if.dmem_req), 32'd0);
        chk({tag, " done vld"}, 32'(mem_vld), 32'd1);
        chk({tag, " done stall"}, 32'(mem_stall), 32'd0);
        chk({tag, " done data"}, mem_data, addr);
    endtask

    initial begin
        rst = 1'b0;
        u_if.dmem_gnt = 1'b0; u_if.dmem_rvalid = 1'b0; u_if.dmem_rdata = '0;
        alu_res = 32'h6; mem_din = '0; mem_ctrl = 5'b10010; ex_vld = 1'b1;
        #3;
        chk("reset req", 32'(u_if.dmem_req), 32'd0);
        chk("reset misaligned", 32'(mem_misal), 32'd0);
        chk("reset addr", u_if.dmem_addr, 32'd0);
        chk("reset be", 32'(u_if.dmem_be), 32'd0);
        chk("reset wdata", u_if.dmem_wdata, 32'd0);

        @(negedge clk);
        rst = 1'b1; alu_res = 32'h1234; mem_ctrl = 5'b00000; ex_vld = 1'b1;
        #1 chk("alu data", mem_data, 32'h1234);
        chk("alu vld", 32'(mem_vld), 32'd1);
        chk("alu stall", 32'(mem_stall), 32'd0);
        chk("alu req", 32'(u_if.dmem_req), 32'd0);

        @(negedge clk);
        alu_res = 32'h40; mem_ctrl = 5'b10010; ex_vld = 1'b0;
        #1 chk("invalid vld", 32'(mem_vld), 32'd0);
        chk("invalid stall", 32'(mem_stall), 32'd0);
        chk("invalid data", mem_data, 32'h40);

        @(negedge clk);
        mem_ctrl = 5'b11010; ex_vld = 1'b1;
        #1 chk("ld+st vld", 32'(mem_vld), 32'd0);
        chk("ld+st stall", 32'(mem_stall), 32'd0);
        chk("ld+st misaligned", 32'(mem_misal), 32'd0);
        @(negedge clk);
        #1 chk("ld+st no req", 32'(u_if.dmem_req), 32'd0);

        @(negedge clk);
        alu_res = 32'h6; mem_ctrl = 5'b10010;
        #1 chk("lw mis flag", 32'(mem_misal), 32'd1);
        chk("lw mis vld", 32'(mem_vld), 32'd0);
        chk("lw mis stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        alu_res = 32'h55; mem_ctrl = 5'b00000;
        #1 chk("lw mis req", 32'(u_if.dmem_req), 32'd0);
        chk("lw mis one cycle", 32'(mem_misal), 32'd0);
        chk("after mis vld", 32'(mem_vld), 32'd1);

        @(negedge clk);
        alu_res = 32'h1; mem_ctrl = 5'b01111;
        #1 chk("odd f3 mis", 32'(mem_misal), 32'd1);
        alu_res = 32'h2; mem_ctrl = 5'b01001;
        #1 chk("sh aligned no mis", 32'(mem_misal), 32'd0);
        alu_res = 32'h3; mem_ctrl = 5'b01001;
        #1 chk("sh odd mis", 32'(mem_misal), 32'd1);
        alu_res = 32'h3; mem_ctrl = 5'b00000;

        store_txn("sb", 32'h103, 3'b000, 32'h000000AB, 4'b1000, 32'hABABABAB, 2);
        store_txn("sh", 32'h102, 3'b001, 32'h12345678, 4'b1100, 32'h56785678, 0);
        store_txn("sw", 32'h108, 3'b010, 32'hCAFEBABE, 4'b1111, 32'hCAFEBABE, 1);
        store_txn("s f3=011", 32'h10C, 3'b011, 32'h01020304, 4'b1111, 32'h01020304, 0);

        load_txn("lb", 32'h2, 3'b000, 32'h00800000, 4'b0100, 32'hFFFFFF80);
        load_txn("lbu", 32'h2, 3'b100, 32'h00800000, 4'b0100, 32'h00000080);
        load_txn("lb pos", 32'h1, 3'b000, 32'h00007F00, 4'b0010, 32'h0000007F);
        load_txn("lh", 32'h2, 3'b001, 32'h80010000, 4'b1100, 32'hFFFF8001);
        load_txn("lhu", 32'h0, 3'b101, 32'h1234F00D, 4'b0011, 32'h0000F00D);
        load_txn("lw", 32'h4, 3'b010, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);

        @(negedge clk);
        alu_res = 32'h8; mem_ctrl = 5'b10010; ex_vld = 1'b1;
        #1 chk("rst-wait accept", 32'(mem_stall), 32'd1);
        @(negedge clk);
        u_if.dmem_gnt = 1'b1;
        #1 chk("rst-wait req", 32'(u_if.dmem_req), 32'd1);
        @(negedge clk);
        u_if.dmem_gnt = 1'b0;
        #1 chk("rst-wait in wait", 32'(mem_stall), 32'd1);
        @(negedge clk);
        rst = 1'b0; ex_vld = 1'b0;
        #1 chk("rst-wait req0", 32'(u_if.dmem_req), 32'd0);
        chk("rst-wait stall0", 32'(mem_stall), 32'd0);
        chk("rst-wait mis0", 32'(mem_misal), 32'd0);
        @(negedge clk);
        rst = 1'b1; u_if.dmem_rvalid = 1'b1; u_if.dmem_rdata = 32'hFFFFFFFF;
        #1 chk("stray rvalid vld", 32'(mem_vld), 32'd0);
        chk("stray rvalid stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        u_if.dmem_rvalid = 1'b0;
        #1 chk("post stray vld", 32'(mem_vld), 32'd0);
        chk("post stray req", 32'(u_if.dmem_req), 32'd0);
        chk("post stray stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        alu_res = 32'h99; mem_ctrl = 5'b00000; ex_vld = 1'b1;
        #1 chk("resume vld", 32'(mem_vld), 32'd1);
        chk("resume data", mem_data, 32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
